// File: rtl/uart_sys_ctrl.sv
// Command sequencer between the UART receiver and the register-file / ALU / UART-TX datapath.
// Parses command frames, issues RF and ALU operations, and returns results byte by byte to the TX.
module uart_sys_ctrl #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int FUN_W    = 4,
  parameter int OPA_ADDR = 0,
  parameter int OPB_ADDR = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   rx_p_data,
  input  logic                rx_d_vld,
  input  logic [DATA_W-1:0]   rf_rd_data,
  input  logic                rf_rd_vld,
  input  logic [2*DATA_W-1:0] alu_out,
  input  logic                alu_out_vld,
  input  logic                tx_busy,
  output logic [ADDR_W-1:0]   rf_addr,
  output logic                rf_wr_en,
  output logic [DATA_W-1:0]   rf_wr_data,
  output logic                rf_rd_en,
  output logic [FUN_W-1:0]    alu_fun,
  output logic                alu_en,
  output logic                clk_gate_en,
  output logic [DATA_W-1:0]   tx_p_data,
  output logic                tx_d_vld,
  output logic                cmd_err
);

  localparam logic [DATA_W-1:0] CMD_WR     = DATA_W'(8'hAA);
  localparam logic [DATA_W-1:0] CMD_RD     = DATA_W'(8'hBB);
  localparam logic [DATA_W-1:0] CMD_ALU_OP = DATA_W'(8'hCC);
  localparam logic [DATA_W-1:0] CMD_ALU    = DATA_W'(8'hDD);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B,
    ALU_FUN, ALU_WAIT, TX_SEND, TX_ACK
  } state_t;

  state_t              state, state_nxt;
  logic                rx_vld_q;
  logic                byte_acc;
  logic [DATA_W-1:0]   tx_byte, tx_byte_nxt;
  logic [DATA_W-1:0]   tx_hi, tx_hi_nxt;
  logic                tx_pend, tx_pend_nxt;
  logic [ADDR_W-1:0]   rf_addr_nxt;
  logic [DATA_W-1:0]   rf_wr_data_nxt, tx_p_data_nxt;
  logic [FUN_W-1:0]    alu_fun_nxt;
  logic                rf_wr_en_nxt, rf_rd_en_nxt, alu_en_nxt;
  logic                clk_gate_en_nxt, tx_d_vld_nxt, cmd_err_nxt;

  // A held-high rx_d_vld level yields exactly one accepted byte.
  assign byte_acc = rx_d_vld & ~rx_vld_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rx_vld_q    <= 1'b0;
      tx_byte     <= '0;
      tx_hi       <= '0;
      tx_pend     <= 1'b0;
      rf_addr     <= '0;
      rf_wr_en    <= 1'b0;
      rf_wr_data  <= '0;
      rf_rd_en    <= 1'b0;
      alu_fun     <= '0;
      alu_en      <= 1'b0;
      clk_gate_en <= 1'b0;
      tx_p_data   <= '0;
      tx_d_vld    <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      rx_vld_q    <= rx_d_vld;
      tx_byte     <= tx_byte_nxt;
      tx_hi       <= tx_hi_nxt;
      tx_pend     <= tx_pend_nxt;
      rf_addr     <= rf_addr_nxt;
      rf_wr_en    <= rf_wr_en_nxt;
      rf_wr_data  <= rf_wr_data_nxt;
      rf_rd_en    <= rf_rd_en_nxt;
      alu_fun     <= alu_fun_nxt;
      alu_en      <= alu_en_nxt;
      clk_gate_en <= clk_gate_en_nxt;
      tx_p_data   <= tx_p_data_nxt;
      tx_d_vld    <= tx_d_vld_nxt;
      cmd_err     <= cmd_err_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    tx_byte_nxt     = tx_byte;
    tx_hi_nxt       = tx_hi;
    tx_pend_nxt     = tx_pend;
    rf_addr_nxt     = rf_addr;
    rf_wr_data_nxt  = rf_wr_data;
    alu_fun_nxt     = alu_fun;
    clk_gate_en_nxt = clk_gate_en;
    tx_p_data_nxt   = tx_p_data;
    rf_wr_en_nxt    = 1'b0;
    rf_rd_en_nxt    = 1'b0;
    alu_en_nxt      = 1'b0;
    tx_d_vld_nxt    = 1'b0;
    cmd_err_nxt     = 1'b0;

    unique case (state)
      IDLE: if (byte_acc) begin
        unique case (rx_p_data)
          CMD_WR:     state_nxt = WR_ADDR;
          CMD_RD:     state_nxt = RD_ADDR;
          CMD_ALU_OP: begin state_nxt = OP_A;    clk_gate_en_nxt = 1'b1; end
          CMD_ALU:    begin state_nxt = ALU_FUN; clk_gate_en_nxt = 1'b1; end
          default:    cmd_err_nxt = 1'b1;
        endcase
      end
      WR_ADDR: if (byte_acc) begin
        rf_addr_nxt = rx_p_data[ADDR_W-1:0];
        state_nxt   = WR_DATA;
      end
      WR_DATA: if (byte_acc) begin
        rf_wr_data_nxt = rx_p_data;
        rf_wr_en_nxt   = 1'b1;
        state_nxt      = IDLE;
      end
      RD_ADDR: if (byte_acc) begin
        rf_addr_nxt  = rx_p_data[ADDR_W-1:0];
        rf_rd_en_nxt = 1'b1;
        state_nxt    = RD_WAIT;
      end
      RD_WAIT: if (rf_rd_vld) begin
        tx_byte_nxt = rf_rd_data;
        tx_pend_nxt = 1'b0;
        state_nxt   = TX_SEND;
      end
      OP_A: if (byte_acc) begin
        rf_addr_nxt    = ADDR_W'(OPA_ADDR);
        rf_wr_data_nxt = rx_p_data;
        rf_wr_en_nxt   = 1'b1;
        state_nxt      = OP_B;
      end
      OP_B: if (byte_acc) begin
        rf_addr_nxt    = ADDR_W'(OPB_ADDR);
        rf_wr_data_nxt = rx_p_data;
        rf_wr_en_nxt   = 1'b1;
        state_nxt      = ALU_FUN;
      end
      ALU_FUN: if (byte_acc) begin
        alu_fun_nxt = rx_p_data[FUN_W-1:0];
        alu_en_nxt  = 1'b1;
        state_nxt   = ALU_WAIT;
      end
      ALU_WAIT: if (alu_out_vld) begin
        tx_byte_nxt     = alu_out[DATA_W-1:0];
        tx_hi_nxt       = alu_out[2*DATA_W-1:DATA_W];
        tx_pend_nxt     = 1'b1;
        clk_gate_en_nxt = 1'b0;
        state_nxt       = TX_SEND;
      end
      TX_SEND: if (!tx_busy) begin
        tx_p_data_nxt = tx_byte;
        tx_d_vld_nxt  = 1'b1;
        state_nxt     = TX_ACK;
      end
      // The MSB is promoted into tx_byte once the TX has taken the LSB.
      TX_ACK: if (tx_busy) begin
        if (tx_pend) begin
          tx_byte_nxt = tx_hi;
          tx_pend_nxt = 1'b0;
          state_nxt   = TX_SEND;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
